muldiv_sequencer: RTL

- Multi-cycle multiply/divide unit that sequences the MUL and DIV function codes, which the single-cycle ALU cannot complete in one cycle.
- Iterative, one partial-product or quotient bit per cycle; start/busy/done handshake to the CPU control unit.
- Result layout matches the ALU: r = low half / quotient, s = high half / remainder.
- Errors go out on a dedicated exception line for the exception unit.

---
 rtl/muldiv_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module muldiv_sequencer #(
    parameter int                           REG_DATA_WIDTH    = 16,
    parameter int                           ALU_CONTROL_WIDTH = 4,
    parameter logic [ALU_CONTROL_WIDTH-1:0] MUL_CODE          = 4'b0001,
    parameter logic [ALU_CONTROL_WIDTH-1:0] DIV_CODE          = 4'b0010
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ALU_CONTROL_WIDTH-1:0] alu_control,
    input  logic [REG_DATA_WIDTH-1:0]    a,
    input  logic [REG_DATA_WIDTH-1:0]    b,
    output logic                         busy,
    output logic                         done,
    output logic [REG_DATA_WIDTH-1:0]    r,
    output logic [REG_DATA_WIDTH-1:0]    s,
    output logic                         exc_muldiv
);

    localparam int W  = REG_DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state_q;
    logic           busy_q, done_q, exc_q;
    logic [W-1:0]   r_q, s_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   hi_q, lo_q, mcand_q;
    logic           op_div_q, neg_res_q, neg_a_q, ovf_q;

    logic           is_mul, is_div, a_neg, b_neg, ovf_d;
    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     mul_sum;
    logic [W+1:0]   div_trial;
    logic [W-1:0]   calc_hi_d, calc_lo_d;
    logic [2*W-1:0] prod_mag, prod;
    logic [W-1:0]   quot, rem;
    logic [W-1:0]   fix_r_d, fix_s_d;

    always_comb begin
        is_mul = (alu_control == MUL_CODE);
        is_div = (alu_control == DIV_CODE);
        a_neg  = SIGNED_EN && a[W-1];
        b_neg  = SIGNED_EN && b[W-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        ovf_d  = SIGNED_EN && is_div && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);

        // Multiply keeps the multiplier in lo_q and shifts the partial product down into it;
        // divide shifts the dividend out of lo_q into the remainder and quotient bits back in.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        div_trial = {1'b0, hi_q, lo_q[W-1]} - {2'b00, mcand_q};
        if (op_div_q) begin
            calc_hi_d = div_trial[W+1] ? {hi_q[W-2:0], lo_q[W-1]} : div_trial[W-1:0];
            calc_lo_d = {lo_q[W-2:0], ~div_trial[W+1]};
        end else begin
            {calc_hi_d, calc_lo_d} = {mul_sum, lo_q[W-1:1]};
        end

        prod_mag = {hi_q, lo_q};
        prod     = neg_res_q ? -prod_mag : prod_mag;
        quot     = neg_res_q ? -lo_q : lo_q;
        rem      = neg_a_q ? -hi_q : hi_q;
        fix_r_d  = op_div_q ? quot : prod[W-1:0];
        fix_s_d  = op_div_q ? rem  : prod[2*W-1:W];
    end

    // NOTE: all state here is written with <= so every register samples pre-edge values;
    // datapath registers are reset too, which keeps r/s defined after an aborted operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            exc_q     <= 1'b0;
            r_q       <= '0;
            s_q       <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            op_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            exc_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (start) begin
                        if (!is_mul && !is_div) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            exc_q   <= 1'b1;
                            r_q     <= '0;
                            s_q     <= '0;
                        end else if (is_div && (b == '0)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            exc_q   <= 1'b1;
                            r_q     <= '0;
                            s_q     <= a;
                        end else begin
                            state_q   <= CALC;
                            busy_q    <= 1'b1;
                            cnt_q     <= CW'(W);
                            hi_q      <= '0;
                            lo_q      <= is_div ? a_mag : b_mag;
                            mcand_q   <= is_div ? b_mag : a_mag;
                            op_div_q  <= is_div;
                            neg_res_q <= a_neg ^ b_neg;
                            neg_a_q   <= a_neg;
                            ovf_q     <= ovf_d;
                        end
                    end
                end
                CALC: begin
                    hi_q  <= calc_hi_d;
                    lo_q  <= calc_lo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    r_q     <= fix_r_d;
                    s_q     <= fix_s_d;
                    exc_q   <= ovf_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign r          = r_q;
    assign s          = s_q;
    assign exc_muldiv = exc_q;

endmodule
